// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-ported memory.
// One transaction is in flight at a time; a stalled memory is released after
// TO_CYC cycles and the requester is told about it through its err flag.
module mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int TO_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last BUSY cycle before the ack wait is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

  state_t              state;
  logic                last_grant;
  logic                owner_q;
  logic [7:0]          count;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   cap_rdata;
  logic                cap_err;
  logic                grant0;
  logic                grant1;

  // Arbitration: a lone requester wins; on a tie the port that did not win last time goes.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (r0_valid && (!r1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (r1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // Transaction FSM: latch on handshake, wait for ack or timeout, then pulse completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      count      <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cap_rdata  <= '0;
      cap_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            lat_we    <= grant1 ? r1_we    : r0_we;
            lat_addr  <= grant1 ? r1_addr  : r0_addr;
            lat_wdata <= grant1 ? r1_wdata : r0_wdata;
            owner_q   <= grant1;
            count     <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (m_ack) begin
            cap_rdata <= lat_we ? '0 : m_rdata;
            cap_err   <= 1'b0;
            state     <= DONE;
          end else if (count == TO_LAST) begin
            cap_rdata <= '0;
            cap_err   <= 1'b1;
            state     <= DONE;
          end else begin
            count <= count + 8'd1;
          end
        end
        DONE: begin
          last_grant <= owner_q;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode: every output is a function of registered state, except the IDLE readies.
  always_comb begin
    r0_ready  = grant0;
    r1_ready  = grant1;
    m_req     = (state == BUSY);
    m_we      = lat_we;
    m_addr    = lat_addr;
    m_wdata   = lat_wdata;
    owner     = owner_q;
    busy      = (state != IDLE);
    r0_rvalid = (state == DONE) && !owner_q;
    r1_rvalid = (state == DONE) && owner_q;
    r0_rdata  = r0_rvalid ? cap_rdata : '0;
    r1_rdata  = r1_rvalid ? cap_rdata : '0;
    r0_err    = r0_rvalid & cap_err;
    r1_err    = r1_rvalid & cap_err;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter checked against a
// transaction-level reference model built on cycle timestamps.
module tb_mem_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int TO_CYC = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              r0_valid, r0_ready, r0_we, r0_rvalid, r0_err;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_valid, r1_ready, r1_we, r1_rvalid, r1_err;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic              m_req, m_we, m_ack;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic              owner, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .owner(owner), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Stimulus knobs (percent probabilities).
  int valid_pct;
  int ack_pct;
  int reset_pct;
  bit force_reset;

  // Reference model: one transaction record plus the cycle it was accepted in.
  bit                md_inflight;
  bit                md_done;
  int                md_port;
  logic              md_we;
  logic [ADDR_W-1:0] md_addr;
  logic [DATA_W-1:0] md_wdata;
  int                md_start;
  logic [DATA_W-1:0] md_rdata;
  logic              md_err;
  int                md_last;
  int                md_owner;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic modelReset();
    md_inflight = 1'b0;
    md_done     = 1'b0;
    md_port     = 0;
    md_we       = 1'b0;
    md_addr     = '0;
    md_wdata    = '0;
    md_start    = 0;
    md_rdata    = '0;
    md_err      = 1'b0;
    md_last     = 1;
    md_owner    = 0;
  endtask

  task automatic applyStimulus();
    reset    = force_reset || ($urandom_range(0, 99) < reset_pct);
    r0_valid = ($urandom_range(0, 99) < valid_pct);
    r1_valid = ($urandom_range(0, 99) < valid_pct);
    r0_we    = $urandom_range(0, 1);
    r1_we    = $urandom_range(0, 1);
    r0_addr  = ADDR_W'($urandom);
    r1_addr  = ADDR_W'($urandom);
    r0_wdata = $urandom;
    r1_wdata = $urandom;
    m_ack    = ($urandom_range(0, 99) < ack_pct);
    m_rdata  = $urandom;
  endtask

  // One clock: drive at negedge, check shortly after, advance the model at posedge.
  task automatic runCycle();
    int  win;
    bit  idle;
    @(negedge clk);
    applyStimulus();
    #1;
    idle = !md_inflight && !md_done;
    if (r0_valid && r1_valid) win = 1 - md_last;
    else if (r0_valid)        win = 0;
    else if (r1_valid)        win = 1;
    else                      win = -1;

    checkOutput("r0_ready", r0_ready, idle && win == 0);
    checkOutput("r1_ready", r1_ready, idle && win == 1);
    checkOutput("m_req", m_req, md_inflight);
    checkOutput("m_we", m_we, md_we);
    checkOutput("m_addr", m_addr, md_addr);
    checkOutput("m_wdata", m_wdata, md_wdata);
    checkOutput("owner", owner, md_owner[0]);
    checkOutput("busy", busy, md_inflight || md_done);
    checkOutput("r0_rvalid", r0_rvalid, md_done && md_port == 0);
    checkOutput("r1_rvalid", r1_rvalid, md_done && md_port == 1);
    checkOutput("r0_rdata", r0_rdata, (md_done && md_port == 0) ? md_rdata : '0);
    checkOutput("r1_rdata", r1_rdata, (md_done && md_port == 1) ? md_rdata : '0);
    checkOutput("r0_err", r0_err, md_done && md_port == 0 && md_err);
    checkOutput("r1_err", r1_err, md_done && md_port == 1 && md_err);

    @(posedge clk);
    if (reset) begin
      modelReset();
    end else if (md_done) begin
      md_done = 1'b0;
      md_last = md_port;
    end else if (md_inflight) begin
      if (m_ack) begin
        md_inflight = 1'b0;
        md_done     = 1'b1;
        md_rdata    = md_we ? '0 : m_rdata;
        md_err      = 1'b0;
      end else if (cyc - md_start == TO_CYC) begin
        md_inflight = 1'b0;
        md_done     = 1'b1;
        md_rdata    = '0;
        md_err      = 1'b1;
      end
    end else if (win >= 0) begin
      md_inflight = 1'b1;
      md_port     = win;
      md_owner    = win;
      md_start    = cyc;
      md_we       = (win == 1) ? r1_we    : r0_we;
      md_addr     = (win == 1) ? r1_addr  : r0_addr;
      md_wdata    = (win == 1) ? r1_wdata : r0_wdata;
    end
    cyc++;
  endtask

  task automatic runPhase(input int n, input int vpct, input int apct, input int rpct, input bit frst);
    valid_pct   = vpct;
    ack_pct     = apct;
    reset_pct   = rpct;
    force_reset = frst;
    for (int i = 0; i < n; i++) runCycle();
  endtask

  initial begin
    reset    = 1'b1;
    r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    m_ack    = 1'b0; m_rdata = '0;
    modelReset();
    repeat (2) @(posedge clk);
    $display("[TB] starting randomized run, TO_CYC=%0d", TO_CYC);

    // Held in reset with spurious acks: all outputs stay zero.
    runPhase(4, 0, 50, 0, 1'b1);
    // Both requesters always valid, fast ack: strict alternation starting with r0.
    runPhase(40, 100, 100, 0, 1'b0);
    // Mixed traffic with slow acks.
    runPhase(300, 50, 30, 0, 1'b0);
    // No acks at all: every transaction times out.
    runPhase(120, 60, 0, 0, 1'b0);
    // Occasional resets landing in any state.
    runPhase(300, 60, 20, 3, 1'b0);
    // Sparse requests with spurious acks while idle.
    runPhase(300, 15, 50, 0, 1'b0);
    // Recovery after a final reset.
    runPhase(2, 0, 0, 0, 1'b1);
    runPhase(100, 70, 40, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data width of requester and memory ports.
REQ-002 Parameter ADDR_W, default 9, address width of requester and memory ports.
REQ-003 Parameter TO_CYC, default 16, memory-ack timeout in cycles; legal range 2..255.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 r0_valid, r1_valid  input  1  requester n presents a transaction.
REQ-007 r0_ready, r1_ready  output  1  transaction accepted this cycle (valid&ready = handshake).
REQ-008 r0_we, r1_we  input  1  1 = write, 0 = read.
REQ-009 r0_addr, r1_addr  input  ADDR_W  word address.
REQ-010 r0_wdata, r1_wdata  input  DATA_W  write data.
REQ-011 r0_rvalid, r1_rvalid  output  1  one-cycle completion pulse to requester n.
REQ-012 r0_rdata, r1_rdata  output  DATA_W  read data, valid with rvalid.
REQ-013 r0_err, r1_err  output  1  timeout flag, valid with rvalid.
REQ-014 m_req  output  1  memory access request, level.
REQ-015 m_we, m_addr, m_wdata  output  1/ADDR_W/DATA_W  latched transaction to memory.
REQ-016 m_ack  input  1  memory completion, sampled only while m_req=1.
REQ-017 m_rdata  input  DATA_W  memory read data, valid with m_ack.
REQ-018 owner  output  1  index of requester currently or last granted.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states IDLE, BUSY, DONE; exactly one transaction in flight.
REQ-021 IDLE: rn_ready = rn_valid & granted(n), combinational; at most one ready high per cycle; no ready outside IDLE.
REQ-022 Arbitration: single valid wins; both valid -> port not equal to last_grant wins; last_grant resets to 1 so r0 wins the first tie.
REQ-023 On handshake: latch we/addr/wdata, set owner, clear timeout counter, go BUSY next cycle.
REQ-024 BUSY: m_req=1 with m_we/m_addr/m_wdata stable until exit; counter increments each BUSY cycle.
REQ-025 BUSY with m_ack=1: capture m_rdata (capture 0 for writes), err=0, go DONE; ack wins over a timeout reached in the same cycle.
REQ-026 BUSY with counter = TO_CYC-1 and m_ack=0: capture rdata=0, err=1, go DONE; m_req low from next cycle.
REQ-027 DONE: r<owner>_rvalid=1 for exactly one cycle with captured rdata/err; last_grant <= owner; return to IDLE.
REQ-028 Non-owner rvalid/rdata/err held 0; rdata/err of owner are 0 whenever its rvalid is 0.
REQ-029 Minimum latency: handshake cycle T, m_req at T+1, ack at T+1 -> rvalid at T+2; next handshake no earlier than T+3.
REQ-030 m_ack while m_req=0 is ignored and has no effect on state.
REQ-031 valid dropped before ready: no transaction, no state change; arbitration re-evaluated each IDLE cycle.

Reset
REQ-032 reset=1 at a clock edge: state IDLE, last_grant=1, owner=0, counter=0, latched fields 0.
REQ-033 During and after reset, before any handshake, all outputs are 0.
REQ-034 Reset mid-transaction: m_req low the cycle after reset is sampled; in-flight transaction dropped, no rvalid issued.

Verification
REQ-035 r0 read addr 0x05, m_ack one cycle after m_req with m_rdata=0xDEADBEEF -> r0_rvalid at T+2, r0_rdata=0xDEADBEEF, r0_err=0.
REQ-036 r0 and r1 valid simultaneously from reset, 4 back-to-back requests each -> grant order r0,r1,r0,r1,...; never two readys in one cycle.
REQ-037 r1 write addr 0x1FF data 0x12345678, ack after 3 cycles -> m_addr/m_wdata stable all 3 BUSY cycles, r1_rvalid with r1_rdata=0, err=0.
REQ-038 TO_CYC=16, m_ack never asserted -> m_req high exactly 16 cycles, then r0_rvalid with r0_err=1, r0_rdata=0.
REQ-039 Spurious m_ack in IDLE, then reset asserted during BUSY -> no state change from ack; m_req low next cycle, no rvalid, next request served normally.
